// File: rtl/alu_arb.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arb
//  Purpose  : Two-requester arbiter around a single shared ALU. The granted
//             requester's op/operands drive the ALU; the result is captured in
//             a one-entry result register and returned to that requester with
//             a valid/ready handshake. Drain and refill can happen in the same
//             cycle, so a steady stream sustains one op per cycle.
//  Ports    : clk, rst (sync, active-high)
//             req_valid[1:0] / req_ready[1:0]  - per-requester request handshake
//             req_op[7:0]                      - op for requester i in [4i+3:4i]
//             req_in0/req_in1[2*N_BITS-1:0]    - operands, slice i per requester
//             resp_valid[1:0] / resp_ready[1:0]- per-requester result handshake
//             resp_out[N_BITS-1:0]             - shared result bus (res_q)
//  Config   : ALU_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins a
//             contention; otherwise contention is resolved round-robin.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_arb #(
    parameter int N_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [7:0]            req_op,
    input  logic [2*N_BITS-1:0]   req_in0,
    input  logic [2*N_BITS-1:0]   req_in1,
    output logic [1:0]            resp_valid,
    input  logic [1:0]            resp_ready,
    output logic [N_BITS-1:0]     resp_out
);

    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    logic [0:0]        state_q,      state_d;
    logic [N_BITS-1:0] res_q,        res_d;
    logic              res_port_q,   res_port_d;
    logic              last_grant_q, last_grant_d;

    logic [1:0]        w_grant;
    logic              w_can_accept;
    logic              w_handshake;
    logic              w_sel;
    logic [3:0]        w_alu_op;
    logic [N_BITS-1:0] w_alu_in0;
    logic [N_BITS-1:0] w_alu_in1;
    logic [N_BITS-1:0] w_alu_out;

    // The register can take a new result if empty, or if its current owner
    // drains it this very cycle.
    assign w_can_accept = (state_q == c_ST_EMPTY) || resp_ready[res_port_q];

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        w_grant = 2'b00;
        if (req_valid[0])      w_grant = 2'b01;
        else if (req_valid[1]) w_grant = 2'b10;
    end
`else
    // On contention the requester that did not win last time goes next.
    always_comb begin
        w_grant = 2'b00;
        case (req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = last_grant_q ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end
`endif

    // Reset blocks acceptance so a request can never slip in during rst.
    assign req_ready   = (w_can_accept && !rst) ? w_grant : 2'b00;
    assign w_handshake = |(req_valid & req_ready);

    // Operand mux follows the grant; when nothing is granted the ALU output
    // is simply not captured.
    assign w_sel     = w_grant[1];
    assign w_alu_op  = w_sel ? req_op[7:4] : req_op[3:0];
    assign w_alu_in0 = w_sel ? req_in0[2*N_BITS-1:N_BITS] : req_in0[N_BITS-1:0];
    assign w_alu_in1 = w_sel ? req_in1[2*N_BITS-1:N_BITS] : req_in1[N_BITS-1:0];

    alu #(
        .N_BITS (N_BITS)
    ) u_alu (
        .alu_op (w_alu_op),
        .in0    (w_alu_in0),
        .in1    (w_alu_in1),
        .out    (w_alu_out)
    );

    always_comb begin
        state_d      = state_q;
        res_d        = res_q;
        res_port_d   = res_port_q;
        last_grant_d = last_grant_q;
        if (w_handshake) begin
            state_d      = c_ST_FULL;
            res_d        = w_alu_out;
            res_port_d   = w_sel;
            last_grant_d = w_sel;
        end else if ((state_q == c_ST_FULL) && resp_ready[res_port_q]) begin
            state_d = c_ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= c_ST_EMPTY;
            res_q        <= '0;
            res_port_q   <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            res_q        <= res_d;
            res_port_q   <= res_port_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign resp_valid = (state_q == c_ST_FULL) ? (res_port_q ? 2'b10 : 2'b01) : 2'b00;
    assign resp_out   = res_q;

endmodule

// ============================================================================
//  Module   : alu
//  Purpose  : Combinational N_BITS ALU shared by alu_arb.
//             Op map: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA,
//             8 SLT (signed), 9 SLTU, 10 NOR, 11 pass in0, 12 pass in1,
//             13..15 zero. Shift amount is the low log2(N_BITS) bits of in1.
//  Ports    : alu_op[3:0], in0/in1[N_BITS-1:0] -> out[N_BITS-1:0]
//  Revision : 1.0 - initial release
// ============================================================================
module alu #(
    parameter int N_BITS = 32
) (
    input  logic [3:0]        alu_op,
    input  logic [N_BITS-1:0] in0,
    input  logic [N_BITS-1:0] in1,
    output logic [N_BITS-1:0] out
);

    localparam int c_SHW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    logic [c_SHW-1:0] w_shamt;
    assign w_shamt = in1[c_SHW-1:0];

    always_comb begin
        out = '0;
        case (alu_op)
            4'd0:    out = in0 + in1;
            4'd1:    out = in0 - in1;
            4'd2:    out = in0 & in1;
            4'd3:    out = in0 | in1;
            4'd4:    out = in0 ^ in1;
            4'd5:    out = in0 << w_shamt;
            4'd6:    out = in0 >> w_shamt;
            4'd7:    out = $unsigned($signed(in0) >>> w_shamt);
            4'd8:    out = {{(N_BITS-1){1'b0}}, ($signed(in0) < $signed(in1))};
            4'd9:    out = {{(N_BITS-1){1'b0}}, (in0 < in1)};
            4'd10:   out = ~(in0 | in1);
            4'd11:   out = in0;
            4'd12:   out = in1;
            default: out = '0;
        endcase
    end

endmodule
`default_nettype wire
